// File: rtl/swan256_key_sched_ctrl_pkg.sv
// Shared definitions for the SWAN256 key schedule sequencer.
// Holds the key/subkey geometry, the rotate distance, the delta increment,
// the default round count and the controller state encoding.
package swan256_pkg;

    localparam int unsigned KEY_SIZE   = 256;
    localparam int unsigned SIDE_SIZE  = 128;
    localparam int unsigned PD         = 120;
    localparam int unsigned ROUNDS_DEF = 64;

    localparam logic [0:SIDE_SIZE-1] DELTA0 = 128'h9e3779b97f4a7c15f39cc0605cedc834;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/swan256_key_sched_ctrl_if.sv
// Key-load and subkey-stream interface of the SWAN256 key schedule sequencer.
//   start/key_in : key-load request and master key (bit 0 = MSB)
//   busy/done    : run status and end-of-run pulse
//   sk_valid/sk_ready/sk/sk_round/sk_last : subkey stream handshake
// master : key loader / round engine side
// slave  : sequencer side
interface swan256_key_sched_ctrl_if;
    import swan256_pkg::*;

    logic                  start;
    logic [0:KEY_SIZE-1]   key_in;
    logic                  busy;
    logic                  sk_valid;
    logic                  sk_ready;
    logic [0:SIDE_SIZE-1]  sk;
    logic [7:0]            sk_round;
    logic                  sk_last;
    logic                  done;

    modport master (
        output start, key_in, sk_ready,
        input  busy, sk_valid, sk, sk_round, sk_last, done
    );

    modport slave (
        input  start, key_in, sk_ready,
        output busy, sk_valid, sk, sk_round, sk_last, done
    );

endinterface

// File: rtl/swan256_key_sched_ctrl_step.sv
// One combinational step of the SWAN256 key schedule.
//   key_i        : current key state (bit 0 = MSB)
//   delta_i      : current delta accumulator
//   next_key_o   : key after rotate-right by PD and lower-half update
//   next_delta_o : delta + DELTA0 (mod 2^128)
//   sk_o         : subkey produced by this step (new lower half)
module enc_key_schedule
    import swan256_pkg::*;
(
    input  logic [0:KEY_SIZE-1]  key_i,
    input  logic [0:SIDE_SIZE-1] delta_i,
    output logic [0:KEY_SIZE-1]  next_key_o,
    output logic [0:SIDE_SIZE-1] next_delta_o,
    output logic [0:SIDE_SIZE-1] sk_o
);

    logic [0:KEY_SIZE-1]  kr;
    logic [0:SIDE_SIZE-1] nd;
    logic [0:SIDE_SIZE-1] s;

    always_comb begin
        // Bit 0 is the MSB, so moving the tail slice to the front is a
        // numeric rotate-right.
        kr           = {key_i[KEY_SIZE-PD:KEY_SIZE-1], key_i[0:KEY_SIZE-1-PD]};
        nd           = delta_i + DELTA0;
        s            = kr[SIDE_SIZE:KEY_SIZE-1] + nd;
        next_key_o   = {kr[0:SIDE_SIZE-1], s};
        next_delta_o = nd;
        sk_o         = s;
    end

endmodule

// File: rtl/swan256_key_sched_ctrl.sv
// SWAN256 key schedule sequencer.
// Loads a master key on start, then streams ROUNDS subkeys over a
// valid/ready handshake, applying one schedule step per accepted subkey.
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active-low
//   ks    : key-load / subkey stream interface (slave side)
module swan256_key_sched_ctrl
    import swan256_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEF
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    swan256_key_sched_ctrl_if.slave  ks
);

    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    state_e               state_q, state_d;
    logic [0:KEY_SIZE-1]  key_q, key_d;
    logic [0:SIDE_SIZE-1] delta_q, delta_d;
    logic [0:SIDE_SIZE-1] sk_q, sk_d;
    logic [7:0]           round_q, round_d;

    logic [0:KEY_SIZE-1]  step_key;
    logic [0:SIDE_SIZE-1] step_delta;
    logic [0:KEY_SIZE-1]  step_next_key;
    logic [0:SIDE_SIZE-1] step_next_delta;
    logic [0:SIDE_SIZE-1] step_sk;

    logic accept;
    logic is_last;
    logic load;
    logic advance;

    // The step is applied when a subkey is registered for presentation, so
    // key_q/delta_q always hold the state after producing the shown subkey.
    // In IDLE the step runs directly on key_in with a zero delta.
    always_comb begin
        if (state_q == ST_IDLE) begin
            step_key   = ks.key_in;
            step_delta = '0;
        end else begin
            step_key   = key_q;
            step_delta = delta_q;
        end
    end

    enc_key_schedule u_step (
        .key_i        (step_key),
        .next_key_o   (step_next_key),
        .delta_i      (step_delta),
        .next_delta_o (step_next_delta),
        .sk_o         (step_sk)
    );

    always_comb begin
        accept  = (state_q == ST_RUN) && ks.sk_ready;
        is_last = (round_q == LAST_ROUND);
        load    = (state_q == ST_IDLE) && ks.start;
        advance = accept && !is_last;
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            delta_q <= '0;
            sk_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            delta_q <= delta_d;
            sk_q    <= sk_d;
            round_q <= round_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ks.start)         state_d = ST_RUN;
            ST_RUN:  if (accept && is_last) state_d = ST_DONE;
            ST_DONE:                       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: step on load or on a non-final handshake
    always_comb begin
        key_d   = key_q;
        delta_d = delta_q;
        sk_d    = sk_q;
        round_d = round_q;
        if (load || advance) begin
            key_d   = step_next_key;
            delta_d = step_next_delta;
            sk_d    = step_sk;
            round_d = load ? '0 : round_q + 8'd1;
        end
    end

    // Outputs decoded from registers only; no path from sk_ready
    always_comb begin
        ks.busy     = (state_q != ST_IDLE);
        ks.sk_valid = (state_q == ST_RUN);
        ks.done     = (state_q == ST_DONE);
        ks.sk_last  = (state_q == ST_RUN) && is_last;
        ks.sk       = sk_q;
        ks.sk_round = round_q;
    end

endmodule

// File: tb/tb_swan256_key_sched_ctrl.sv
// Self-checking bench for swan256_key_sched_ctrl: a 64-round instance under
// random keys and random backpressure, and a 1-round instance, both checked
// against a numeric reference model of the key schedule.
module tb_swan256_key_sched_ctrl;

    localparam int unsigned RA = 64;
    localparam logic [127:0] D0 = 128'h9e3779b97f4a7c15f39cc0605cedc834;

    logic clk;
    logic rst_n;

    int unsigned n_checks;
    int unsigned n_pass;

    logic [127:0] exp_sk [0:RA-1];
    logic [127:0] got_sk [0:RA-1];

    swan256_key_sched_ctrl_if ifa ();
    swan256_key_sched_ctrl_if ifb ();

    swan256_key_sched_ctrl #(.ROUNDS(RA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ifa)
    );

    swan256_key_sched_ctrl #(.ROUNDS(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: key as a 256-bit number, rotate right 120, add deltas.
    task automatic model(input logic [255:0] key);
        logic [255:0] k;
        logic [255:0] kr;
        logic [127:0] d;
        logic [127:0] s;
        k = key;
        d = '0;
        for (int r = 0; r < RA; r++) begin
            kr = (k >> 120) | (k << 136);
            d  = d + D0;
            s  = kr[127:0] + d;
            k  = {kr[255:128], s};
            exp_sk[r] = s;
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++)
            k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    // Called on a negedge with dut_a idle. abort_at >= RA means no abort.
    task automatic run_seq(input logic [255:0] key, input int unsigned duty,
                           input bit mid_start, input bit start_at_done,
                           input int unsigned abort_at);
        int unsigned er;
        int unsigned cyc;
        model(key);
        ifa.key_in   = key;
        ifa.start    = 1'b1;
        ifa.sk_ready = 1'b0;
        @(negedge clk);
        er  = 0;
        cyc = 0;
        while (er < RA && cyc < 4000) begin
            ifa.start = 1'b0;
            if (er == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk("abort_valid", 256'(ifa.sk_valid), 256'(0));
                chk("abort_busy",  256'(ifa.busy),     256'(0));
                chk("abort_done",  256'(ifa.done),     256'(0));
                chk("abort_sk",    256'(ifa.sk),       256'(0));
                chk("abort_round", 256'(ifa.sk_round), 256'(0));
                repeat (5) begin
                    @(negedge clk);
                    chk("abort_no_done", 256'(ifa.done), 256'(0));
                    chk("abort_idle",    256'(ifa.busy), 256'(0));
                end
                return;
            end
            chk("sk_valid", 256'(ifa.sk_valid), 256'(1));
            chk("busy",     256'(ifa.busy),     256'(1));
            chk("done_low", 256'(ifa.done),     256'(0));
            chk("sk",       256'(ifa.sk),       256'(exp_sk[er]));
            chk("sk_round", 256'(ifa.sk_round), 256'(er));
            chk("sk_last",  256'(ifa.sk_last),  256'(er == RA - 1));
            got_sk[er] = ifa.sk;
            if (mid_start && er == 20) begin
                ifa.start  = 1'b1;
                ifa.key_in = ~key;
            end
            ifa.sk_ready = ($urandom_range(99) < duty);
            if (ifa.sk_ready) er++;
            @(negedge clk);
            cyc++;
        end
        ifa.start    = 1'b0;
        ifa.sk_ready = 1'b0;
        chk("run_complete", 256'(er), 256'(RA));
        if (duty >= 100)
            chk("run_cycles", 256'(cyc), 256'(RA));
        chk("done_pulse", 256'(ifa.done),     256'(1));
        chk("done_valid", 256'(ifa.sk_valid), 256'(0));
        chk("done_busy",  256'(ifa.busy),     256'(1));
        if (start_at_done) begin
            ifa.start  = 1'b1;
            ifa.key_in = ~key;
        end
        @(negedge clk);
        ifa.start = 1'b0;
        chk("post_done",  256'(ifa.done),     256'(0));
        chk("post_busy",  256'(ifa.busy),     256'(0));
        chk("post_valid", 256'(ifa.sk_valid), 256'(0));
        @(negedge clk);
        chk("idle_busy",  256'(ifa.busy),     256'(0));
        chk("idle_valid", 256'(ifa.sk_valid), 256'(0));
    endtask

    initial begin
        logic [255:0] k;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        ifa.start = 1'b0; ifa.key_in = '0; ifa.sk_ready = 1'b0;
        ifb.start = 1'b0; ifb.key_in = '0; ifb.sk_ready = 1'b0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("rst_busy",  256'(ifa.busy),     256'(0));
            chk("rst_valid", 256'(ifa.sk_valid), 256'(0));
            chk("rst_done",  256'(ifa.done),     256'(0));
            chk("rst_last",  256'(ifa.sk_last),  256'(0));
            chk("rst_sk",    256'(ifa.sk),       256'(0));
            chk("rst_round", 256'(ifa.sk_round), 256'(0));
            chk("rst_b_valid", 256'(ifb.sk_valid), 256'(0));
        end

        // Zero key, ready tied high
        run_seq('0, 100, 1'b0, 1'b0, RA);
        chk("zero_sk0", 256'(got_sk[0]), 256'(128'h9e3779b97f4a7c15f39cc0605cedc834));
        chk("zero_sk1", 256'(got_sk[1]), 256'(128'h3c6ef372fe94f82be73980c0b9db9106));

        // Random keys: full throughput, then 30% ready duty
        for (int i = 0; i < 3; i++) begin
            k = rand_key();
            run_seq(k, 100, 1'b0, 1'b0, RA);
            run_seq(k, 30,  1'b0, 1'b0, RA);
        end

        // start while busy and start during DONE are ignored
        run_seq(rand_key(), 100, 1'b1, 1'b1, RA);
        run_seq(rand_key(), 50,  1'b1, 1'b1, RA);

        // Reset mid-run, then a fresh run
        run_seq(rand_key(), 100, 1'b0, 1'b0, 10);
        run_seq(rand_key(), 100, 1'b0, 1'b0, RA);

        // Single-round build, with a few stalled cycles before accept
        k = rand_key();
        model(k);
        ifb.key_in = k;
        ifb.start  = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("r1_valid", 256'(ifb.sk_valid), 256'(1));
            chk("r1_last",  256'(ifb.sk_last),  256'(1));
            chk("r1_round", 256'(ifb.sk_round), 256'(0));
            chk("r1_sk",    256'(ifb.sk),       256'(exp_sk[0]));
            ifb.sk_ready = (i == 2);
            @(negedge clk);
        end
        ifb.sk_ready = 1'b0;
        chk("r1_done",       256'(ifb.done),     256'(1));
        chk("r1_done_busy",  256'(ifb.busy),     256'(1));
        chk("r1_done_valid", 256'(ifb.sk_valid), 256'(0));
        @(negedge clk);
        chk("r1_post_done", 256'(ifb.done), 256'(0));
        chk("r1_post_busy", 256'(ifb.busy), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
